l1_writeback_buffer: RTL and testbench
======================================

# l1_writeback_buffer

Write-back buffer between the direct-mapped, write-back L1 data cache and the four-way L2. It accepts dirty 16-byte blocks evicted by the L1 controller and queues up to DEPTH of them. It drains each block to L2 as a four-beat word burst. It also answers single-cycle-latency lookups, so an L1 miss to a block still in the buffer is served from the buffer instead of from stale L2 data.

## Interface
- DEPTH, 4: number of block entries; power of two, at least 2.
- ADDRESS_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: L2 burst beat width (one word).
- WORDS_PER_BLOCK, 4: beats per block. Block data width is DATA_WIDTH*WORDS_PER_BLOCK = 128 bits.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- evict_valid  in  1  L1 presents a dirty victim block.
- evict_ready  out  1  buffer can accept; equals (count < DEPTH).
- evict_addr  in  ADDRESS_WIDTH  block address; bits [3:0] are ignored and stored as 0.
- evict_data  in  128  block data; word i is bits [32i+31:32i].
- wb_valid  out  1  burst beat valid toward L2.
- wb_ready  in  1  L2 accepts the beat.
- wb_addr  out  ADDRESS_WIDTH  head block address + 4*beat.
- wb_data  out  DATA_WIDTH  word[beat] of the head block.
- wb_last  out  1  high on beat WORDS_PER_BLOCK-1.
- lookup_valid  in  1  L1 miss probe.
- lookup_addr  in  ADDRESS_WIDTH  probe address; compared on bits [31:4].
- lookup_hit  out  1  registered hit result.
- lookup_data  out  128  registered matching block.
- count  out  $clog2(DEPTH+1)  occupied entries.
- buf_empty  out  1  high when count == 0.

## Operation
- The storage is a circular FIFO: head pointer, tail pointer and count. Each entry holds {addr[31:4], data[127:0]}.
- **Enqueue** occurs on evict_valid && evict_ready.
  - **Merge rule:** if a valid entry whose block address matches evict_addr exists and it is not the head while the drain FSM is in BURST, that entry's data is overwritten in place. Count, the pointers and evict_ready are unchanged by a merge.
  - Otherwise the block is written at the tail and count increments.
- Drain FSM states:
  - IDLE: wb_valid = 0. Moves to BURST when count > 0, with beat = 0.
  - BURST: wb_valid = 1, and wb_addr, wb_data and wb_last are taken from the head entry and the beat counter. Each beat advances on wb_valid && wb_ready.
  - When the last beat is accepted, the head is popped and count decrements. The FSM goes to IDLE if the resulting count is 0; otherwise it stays in BURST with beat = 0.
- **Simultaneous push and pop:** count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- **Full:** evict_ready = 0. It is not raised early by a pop occurring in the same cycle.
- **Lookup:** all valid entries are compared in parallel. If several entries match, the youngest wins; this can only be the in-flight head plus a newer copy. The head keeps hitting until its last beat is accepted.
- **Lookup in the same cycle as an enqueue or merge** to the same block: the result reflects the pre-write contents.

## Timing
- Reset values:
  - count = 0, buf_empty = 1, evict_ready = 1.
  - wb_valid = 0, wb_last = 0, wb_addr = 0, wb_data = 0.
  - lookup_hit = 0, lookup_data = 0.
  - FSM in IDLE, pointers at 0, beat = 0.
- **Reset asserted mid-burst:** all entries are discarded and wb_valid falls asynchronously.
- **wb outputs are registered.** A block enqueued into an empty buffer in cycle N gives first wb_valid in cycle N+1.
- **Best-case drain:** one block takes WORDS_PER_BLOCK cycles. Back-to-back blocks run with no IDLE bubble.
- **Valid/ready hold rule:** while wb_valid = 1 and wb_ready = 0, wb_addr, wb_data and wb_last hold stable, and wb_valid never drops.
- **Lookup latency:** lookup_valid in cycle N gives lookup_hit and lookup_data valid in cycle N+1.
  - lookup_hit is 0 in any cycle following lookup_valid = 0.
  - lookup_data holds its last value.

## Configuration
- WB_FORWARD_EN:
  - Defined: the lookup compare and forwarding logic are built as described.
  - Undefined: no compare logic is built, and lookup_hit and lookup_data are tied to 0. The L1 controller must then wait for buf_empty before issuing any L2 read.
  - Merge and drain behaviour are identical in both builds.

## Test plan
- **Single evict, L2 always ready:** evict 0x0000_1230 with data words {0x11, 0x22, 0x33, 0x44} -> four beats to addresses 0x1230, 0x1234, 0x1238, 0x123C, data 0x11..0x44, wb_last on beat 3, count returns to 0.
- **Fill with wb_ready = 0:** evict 4 distinct blocks -> evict_ready = 0 and count = 4. Raise wb_ready -> blocks drain in order with no bubble between bursts.
- **Backpressure:** toggle wb_ready every cycle -> beats are never lost or duplicated, and outputs stay stable while stalled.
- **Merge:**
  - Enqueue block A, then block B. Evict A again with new data while A is the in-flight head -> new entry appended, count = 3.
  - Evict B again -> B is overwritten in place, count unchanged, and B drains with the new data.
- **Forwarding** (WB_FORWARD_EN defined):
  - Lookup A while A is queued -> next cycle lookup_hit = 1 with A's data.
  - Lookup after A's last beat is accepted -> lookup_hit = 0.
  - Undefined build -> lookup_hit is always 0.
- **Reset mid-burst:** assert rst_n = 0 during beat 2 -> wb_valid = 0 immediately, count = 0, and no beats are issued after release.

Source files
------------

// File: rtl/l1_writeback_buffer.sv
// l1_writeback_buffer: queues dirty 16-byte L1 victims and drains each one
// to L2 as a word burst, while answering single-cycle lookups so that an L1
// miss to a block still sitting here is served from the buffer.
// Optional feature macro: WB_FORWARD_EN builds the lookup compare/forwarding
// path; without it lookup_hit and lookup_data are tied to zero.
//
// Handshake: a wb beat transfers on a rising edge where wb_valid && wb_ready;
// once wb_valid is high it stays high, and wb_addr/wb_data/wb_last hold
// stable, until that transfer happens. An eviction is taken on
// evict_valid && evict_ready.
module l1_writeback_buffer #(
    parameter int DEPTH           = 4,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  evict_valid,
    output logic                                  evict_ready,
    input  logic [ADDRESS_WIDTH-1:0]              evict_addr,
    input  logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] evict_data,
    output logic                                  wb_valid,
    input  logic                                  wb_ready,
    output logic [ADDRESS_WIDTH-1:0]              wb_addr,
    output logic [DATA_WIDTH-1:0]                 wb_data,
    output logic                                  wb_last,
    input  logic                                  lookup_valid,
    input  logic [ADDRESS_WIDTH-1:0]              lookup_addr,
    output logic                                  lookup_hit,
    output logic [DATA_WIDTH*WORDS_PER_BLOCK-1:0] lookup_data,
    output logic [$clog2(DEPTH+1)-1:0]            count,
    output logic                                  buf_empty,
    output logic                                  dbg_state
);
    localparam int BLOCK_W = DATA_WIDTH * WORDS_PER_BLOCK;
    localparam int BEAT_W  = $clog2(WORDS_PER_BLOCK);
    localparam int BYTE_W  = $clog2(DATA_WIDTH / 8);
    localparam int OFF_W   = BEAT_W + BYTE_W;
    localparam int TAG_W   = ADDRESS_WIDTH - OFF_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    logic [TAG_W-1:0]   tag_mem  [DEPTH];
    logic [BLOCK_W-1:0] data_mem [DEPTH];

    state_t             state_q, state_n;
    logic [PTR_W-1:0]   head_q, head_n, tail_q, tail_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic [BEAT_W-1:0]  beat_q, beat_n;

    logic               wb_valid_q, wb_last_q;
    logic [ADDRESS_WIDTH-1:0] wb_addr_q;
    logic [DATA_WIDTH-1:0]    wb_data_q;

    logic [PTR_W-1:0]   age_idx [DEPTH];
    logic [DEPTH-1:0]   age_valid;
    logic [TAG_W-1:0]   evict_tag;
    logic               merge_hit;
    logic [PTR_W-1:0]   merge_idx;
    logic               wr_en, push, pop;
    logic [PTR_W-1:0]   wr_idx;
    logic [TAG_W-1:0]   nxt_tag;
    logic [BLOCK_W-1:0] nxt_data;
    logic               unused_addr_bits;

    assign evict_tag   = evict_addr[ADDRESS_WIDTH-1:OFF_W];
    assign evict_ready = (count_q < CNT_W'(DEPTH));
    assign count       = count_q;
    assign buf_empty   = (count_q == '0);
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign wb_last     = wb_last_q;
    assign dbg_state   = state_q;

    // Entries ordered oldest (offset 0 = head) to youngest, with occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_idx[i]   = head_q + PTR_W'(i);
            age_valid[i] = (CNT_W'(i) < count_q);
        end
    end

    // Merge target: a queued copy of the evicted block other than the head
    // that is currently bursting out.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_valid[i] && (i != 0 || state_q != BURST) &&
                tag_mem[age_idx[i]] == evict_tag) begin
                merge_hit = 1'b1;
                merge_idx = age_idx[i];
            end
        end
    end

    // Queue bookkeeping and drain FSM next state.
    always_comb begin
        wr_en   = evict_valid && evict_ready;
        push    = wr_en && !merge_hit;
        wr_idx  = merge_hit ? merge_idx : tail_q;
        pop     = wb_valid_q && wb_ready && (beat_q == LAST_BEAT);
        count_n = count_q + CNT_W'(push) - CNT_W'(pop);
        head_n  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_n  = push ? tail_q + PTR_W'(1) : tail_q;
        state_n = state_q;
        beat_n  = beat_q;
        case (state_q)
            IDLE: begin
                if (count_n != '0) begin
                    state_n = BURST;
                    beat_n  = '0;
                end
            end
            BURST: begin
                if (wb_valid_q && wb_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_n = '0;
                        if (count_n == '0) state_n = IDLE;
                    end else begin
                        beat_n = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // The next head may be written this very cycle (enqueue into an
        // emptying buffer, or a merge into the entry about to become head).
        if (wr_en && wr_idx == head_n) begin
            nxt_tag  = evict_tag;
            nxt_data = evict_data;
        end else begin
            nxt_tag  = tag_mem[head_n];
            nxt_data = data_mem[head_n];
        end
    end

    // Control state, pointers and the registered burst outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            beat_q     <= '0;
            wb_valid_q <= 1'b0;
            wb_last_q  <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_n;
            head_q     <= head_n;
            tail_q     <= tail_n;
            count_q    <= count_n;
            beat_q     <= beat_n;
            wb_valid_q <= (state_n == BURST);
            wb_last_q  <= (state_n == BURST) && (beat_n == LAST_BEAT);
            if (state_n == BURST) begin
                wb_addr_q <= {nxt_tag, beat_n, {BYTE_W{1'b0}}};
                wb_data_q <= nxt_data[beat_n*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                wb_addr_q <= '0;
                wb_data_q <= '0;
            end
        end
    end

    // Block storage; occupancy is tracked by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= evict_tag;
            data_mem[wr_idx] <= evict_data;
        end
    end

`ifdef WB_FORWARD_EN
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic [BLOCK_W-1:0] lk_data;
    logic               lookup_hit_q;
    logic [BLOCK_W-1:0] lookup_data_q;

    assign lk_tag           = lookup_addr[ADDRESS_WIDTH-1:OFF_W];
    assign unused_addr_bits = ^{evict_addr[OFF_W-1:0], lookup_addr[OFF_W-1:0]};
    assign lookup_hit       = lookup_hit_q;
    assign lookup_data      = lookup_data_q;

    // Parallel compare against pre-write contents; the youngest match wins.
    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_valid[i] && tag_mem[age_idx[i]] == lk_tag) begin
                lk_hit  = 1'b1;
                lk_data = data_mem[age_idx[i]];
            end
        end
    end

    // Register the lookup result; data holds its last forwarded block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_hit_q  <= 1'b0;
            lookup_data_q <= '0;
        end else begin
            lookup_hit_q <= lookup_valid && lk_hit;
            if (lookup_valid && lk_hit) lookup_data_q <= lk_data;
        end
    end
`else
    assign unused_addr_bits = ^{evict_addr[OFF_W-1:0], lookup_addr, lookup_valid};
    assign lookup_hit       = 1'b0;
    assign lookup_data      = '0;
`endif

endmodule

// File: tb/tb_l1_writeback_buffer.sv
// Directed testbench for l1_writeback_buffer (default parameters).
// Outputs are sampled and inputs are driven on the falling clock edge.
module tb_l1_writeback_buffer;
    logic         clk;
    logic         rst_n;
    logic         evict_valid;
    logic         evict_ready;
    logic [31:0]  evict_addr;
    logic [127:0] evict_data;
    logic         wb_valid;
    logic         wb_ready;
    logic [31:0]  wb_addr;
    logic [31:0]  wb_data;
    logic         wb_last;
    logic         lookup_valid;
    logic [31:0]  lookup_addr;
    logic         lookup_hit;
    logic [127:0] lookup_data;
    logic [2:0]   count;
    logic         buf_empty;
    logic         dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    l1_writeback_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .evict_valid  (evict_valid),
        .evict_ready  (evict_ready),
        .evict_addr   (evict_addr),
        .evict_data   (evict_data),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_last      (wb_last),
        .lookup_valid (lookup_valid),
        .lookup_addr  (lookup_addr),
        .lookup_hit   (lookup_hit),
        .lookup_data  (lookup_data),
        .count        (count),
        .buf_empty    (buf_empty),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // Block with word i = base + i
    function automatic logic [127:0] mk_blk(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    task automatic drive_evict(input logic [31:0] addr, input logic [127:0] data);
        evict_valid = 1'b1;
        evict_addr  = addr;
        evict_data  = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", buf_empty); end
        checks++; if (evict_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", evict_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        checks++; if (wb_last !== 1'b0) begin errors++; $display("FAIL reset_wb_last: got %b expected 0", wb_last); end
        checks++; if (wb_addr !== 32'h0) begin errors++; $display("FAIL reset_wb_addr: got %h expected 0", wb_addr); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", wb_data); end
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL reset_lookup_hit: got %b expected 0", lookup_hit); end
        checks++; if (lookup_data !== 128'h0) begin errors++; $display("FAIL reset_lookup_data: got %h expected 0", lookup_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0] ea;
        logic [31:0] ed;
        wb_ready = 1'b1;
        @(negedge clk);
        checks++; if (evict_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", evict_ready); end
        drive_evict(32'h0000_1230, {32'h44, 32'h33, 32'h22, 32'h11});
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            evict_valid = 1'b0;
            ea = 32'h0000_1230 + 32'(4 * b);
            ed = 32'h11 * 32'(b + 1);
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL single_valid b%0d: got %b expected 1", b, wb_valid); end
            checks++; if (wb_addr !== ea) begin errors++; $display("FAIL single_addr b%0d: got %h expected %h", b, wb_addr, ea); end
            checks++; if (wb_data !== ed) begin errors++; $display("FAIL single_data b%0d: got %h expected %h", b, wb_data, ed); end
            checks++; if (wb_last !== (b == 3)) begin errors++; $display("FAIL single_last b%0d: got %b expected %b", b, wb_last, b == 3); end
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count b%0d: got %0d expected 1", b, count); end
        end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_end_valid: got %b expected 0", wb_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_end_count: got %0d expected 0", count); end
        checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL single_end_empty: got %b expected 1", buf_empty); end
        wb_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic [31:0] ea;
        logic [31:0] ed;
        wb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_evict(32'h0001_0000 + 32'(k) * 32'h100, mk_blk(32'h1000 * 32'(k + 1)));
            for (int w = 0; w < 4; w++) exp_q.push_back(32'h1000 * 32'(k + 1) + 32'(w));
        end
        @(negedge clk);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
        checks++; if (evict_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", evict_ready); end
        checks++; if (buf_empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b expected 0", buf_empty); end
        drive_evict(32'h0001_0500, mk_blk(32'h5000));
        @(negedge clk);
        evict_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_refused: got %0d expected 4", count); end
        wb_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            if (j > 0) @(negedge clk);
            ea = 32'h0001_0000 + 32'(j / 4) * 32'h100 + 32'(4 * (j % 4));
            ed = exp_q.pop_front();
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL drain_valid j%0d: got %b expected 1", j, wb_valid); end
            checks++; if (wb_addr !== ea) begin errors++; $display("FAIL drain_addr j%0d: got %h expected %h", j, wb_addr, ea); end
            checks++; if (wb_data !== ed) begin errors++; $display("FAIL drain_data j%0d: got %h expected %h", j, wb_data, ed); end
            checks++; if (wb_last !== (j % 4 == 3)) begin errors++; $display("FAIL drain_last j%0d: got %b expected %b", j, wb_last, j % 4 == 3); end
            checks++; if (count !== 3'(4 - j / 4)) begin errors++; $display("FAIL drain_count j%0d: got %0d expected %0d", j, count, 4 - j / 4); end
            checks++; if (evict_ready !== (j >= 4)) begin errors++; $display("FAIL drain_ready j%0d: got %b expected %b", j, evict_ready, j >= 4); end
        end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL drain_end_valid: got %b expected 0", wb_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_end_count: got %0d expected 0", count); end
        wb_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int beat;
        beat = 0;
        wb_ready = 1'b0;
        @(negedge clk);
        drive_evict(32'h0000_5670, mk_blk(32'hA0));
        @(negedge clk);
        evict_valid = 1'b0;
        for (int c = 0; c < 16 && beat < 4; c++) begin
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %b expected 1", c, wb_valid); end
            checks++; if (wb_addr !== 32'h0000_5670 + 32'(4 * beat)) begin errors++; $display("FAIL bp_addr c%0d: got %h expected %h", c, wb_addr, 32'h0000_5670 + 32'(4 * beat)); end
            checks++; if (wb_data !== 32'hA0 + 32'(beat)) begin errors++; $display("FAIL bp_data c%0d: got %h expected %h", c, wb_data, 32'hA0 + 32'(beat)); end
            checks++; if (wb_last !== (beat == 3)) begin errors++; $display("FAIL bp_last c%0d: got %b expected %b", c, wb_last, beat == 3); end
            wb_ready = c[0];
            @(negedge clk);
            if (wb_ready) beat++;
        end
        wb_ready = 1'b0;
        checks++; if (beat !== 4) begin errors++; $display("FAIL bp_beats: got %0d expected 4", beat); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b expected 0", wb_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL bp_end_count: got %0d expected 0", count); end
    endtask

    task automatic test_merge();
        logic [127:0] da1, da2, db1, db2;
        logic [31:0]  blk_addr [3];
        logic [31:0]  blk_base [3];
        logic [31:0]  ea;
        logic [31:0]  ed;
        da1 = mk_blk(32'hA100);
        da2 = mk_blk(32'hA200);
        db1 = mk_blk(32'hB100);
        db2 = mk_blk(32'hB200);
        blk_addr[0] = 32'h0A00; blk_base[0] = 32'hA100;
        blk_addr[1] = 32'h0B00; blk_base[1] = 32'hB200;
        blk_addr[2] = 32'h0A00; blk_base[2] = 32'hA200;
        wb_ready = 1'b0;
        @(negedge clk);
        drive_evict(32'h0000_0A00, da1);
        @(negedge clk);
        drive_evict(32'h0000_0B00, db1);
        @(negedge clk);
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL merge_count2: got %0d expected 2", count); end
        drive_evict(32'h0000_0A00, da2);
        @(negedge clk);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL merge_append: got %0d expected 3", count); end
        drive_evict(32'h0000_0B00, db2);
        lookup_valid = 1'b1;
        lookup_addr  = 32'h0000_0B04;
        @(negedge clk);
        evict_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL merge_inplace: got %0d expected 3", count); end
        checks++; if (evict_ready !== 1'b1) begin errors++; $display("FAIL merge_ready: got %b expected 1", evict_ready); end
        checks++; if (lookup_hit !== FWD) begin errors++; $display("FAIL fwd_prewrite_hit: got %b expected %b", lookup_hit, FWD); end
        checks++; if (lookup_data !== (FWD ? db1 : 128'h0)) begin errors++; $display("FAIL fwd_prewrite_data: got %h expected %h", lookup_data, FWD ? db1 : 128'h0); end
        lookup_addr = 32'h0000_0B00;
        @(negedge clk);
        checks++; if (lookup_hit !== FWD) begin errors++; $display("FAIL fwd_merged_hit: got %b expected %b", lookup_hit, FWD); end
        checks++; if (lookup_data !== (FWD ? db2 : 128'h0)) begin errors++; $display("FAIL fwd_merged_data: got %h expected %h", lookup_data, FWD ? db2 : 128'h0); end
        lookup_addr = 32'h0000_0A0C;
        @(negedge clk);
        checks++; if (lookup_hit !== FWD) begin errors++; $display("FAIL fwd_youngest_hit: got %b expected %b", lookup_hit, FWD); end
        checks++; if (lookup_data !== (FWD ? da2 : 128'h0)) begin errors++; $display("FAIL fwd_youngest_data: got %h expected %h", lookup_data, FWD ? da2 : 128'h0); end
        lookup_valid = 1'b0;
        wb_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            if (j > 0) @(negedge clk);
            if (j == 1) begin
                checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL fwd_idle_hit: got %b expected 0", lookup_hit); end
                checks++; if (lookup_data !== (FWD ? da2 : 128'h0)) begin errors++; $display("FAIL fwd_hold_data: got %h expected %h", lookup_data, FWD ? da2 : 128'h0); end
            end
            ea = blk_addr[j / 4] + 32'(4 * (j % 4));
            ed = blk_base[j / 4] + 32'(j % 4);
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL merge_valid j%0d: got %b expected 1", j, wb_valid); end
            checks++; if (wb_addr !== ea) begin errors++; $display("FAIL merge_addr j%0d: got %h expected %h", j, wb_addr, ea); end
            checks++; if (wb_data !== ed) begin errors++; $display("FAIL merge_data j%0d: got %h expected %h", j, wb_data, ed); end
            checks++; if (count !== 3'(3 - j / 4)) begin errors++; $display("FAIL merge_drain_count j%0d: got %0d expected %0d", j, count, 3 - j / 4); end
        end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL merge_end_valid: got %b expected 0", wb_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL merge_end_count: got %0d expected 0", count); end
        wb_ready = 1'b0;
    endtask

    task automatic test_forward();
        logic [127:0] df;
        df = mk_blk(32'hF00);
        wb_ready = 1'b0;
        @(negedge clk);
        drive_evict(32'h0000_0F00, df);
        @(negedge clk);
        evict_valid  = 1'b0;
        lookup_valid = 1'b1;
        lookup_addr  = 32'h0000_0F08;
        @(negedge clk);
        checks++; if (lookup_hit !== FWD) begin errors++; $display("FAIL fwd_queued_hit: got %b expected %b", lookup_hit, FWD); end
        checks++; if (lookup_data !== (FWD ? df : 128'h0)) begin errors++; $display("FAIL fwd_queued_data: got %h expected %h", lookup_data, FWD ? df : 128'h0); end
        lookup_addr = 32'h0000_0E00;
        wb_ready = 1'b1;
        @(negedge clk);
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss_hit: got %b expected 0", lookup_hit); end
        checks++; if (lookup_data !== (FWD ? df : 128'h0)) begin errors++; $display("FAIL fwd_miss_hold: got %h expected %h", lookup_data, FWD ? df : 128'h0); end
        checks++; if (wb_addr !== 32'h0000_0F04) begin errors++; $display("FAIL fwd_beat1_addr: got %h expected 00000f04", wb_addr); end
        lookup_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (wb_last !== 1'b1) begin errors++; $display("FAIL fwd_last_beat: got %b expected 1", wb_last); end
        lookup_valid = 1'b1;
        lookup_addr  = 32'h0000_0F00;
        @(negedge clk);
        checks++; if (lookup_hit !== FWD) begin errors++; $display("FAIL fwd_lastbeat_hit: got %b expected %b", lookup_hit, FWD); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fwd_end_valid: got %b expected 0", wb_valid); end
        @(negedge clk);
        lookup_valid = 1'b0;
        checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL fwd_popped_hit: got %b expected 0", lookup_hit); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL fwd_end_count: got %0d expected 0", count); end
        wb_ready = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        int bad_cycles;
        bad_cycles = 0;
        wb_ready = 1'b1;
        @(negedge clk);
        drive_evict(32'h0000_0C00, mk_blk(32'hC00));
        @(negedge clk);
        drive_evict(32'h0000_0D00, mk_blk(32'hD00));
        @(negedge clk);
        evict_valid = 1'b0;
        @(negedge clk);
        checks++; if (wb_addr !== 32'h0000_0C08) begin errors++; $display("FAIL rst_beat2_addr: got %h expected 00000c08", wb_addr); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", wb_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_async_count: got %0d expected 0", count); end
        checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL rst_async_empty: got %b expected 1", buf_empty); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (wb_valid !== 1'b0 || count !== 3'd0) bad_cycles++;
        end
        checks++; if (bad_cycles !== 0) begin errors++; $display("FAIL rst_no_beats: got %0d active cycles expected 0", bad_cycles); end
        checks++; if (evict_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", evict_ready); end
        wb_ready = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        evict_valid  = 1'b0;
        evict_addr   = '0;
        evict_data   = '0;
        wb_ready     = 1'b0;
        lookup_valid = 1'b0;
        lookup_addr  = '0;
        test_reset();
        test_single();
        test_fill_drain();
        test_backpressure();
        test_merge();
        test_forward();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
